// File: rtl/mc_seq_ctrl_if.sv
// mc_seq_ctrl_if: sequencer bus (fetch/data SRAM handshakes, decoder hints, status/perf outputs); master = mc_seq_ctrl, slave = environment
interface mc_seq_ctrl_if #(parameter int ADDR_W = 32);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_ready;
    logic [31:0]       inst_rdata;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc;
    logic              dec_mem_rd;
    logic              dec_mem_wr;
    logic              dec_wb_en;
    logic              dec_redirect;
    logic [ADDR_W-1:0] dec_target;
    logic              data_req;
    logic              data_we;
    logic              data_ready;
    logic              st_exec;
    logic              rf_wen;
    logic              exc;
    logic              retire;
    logic [ADDR_W-1:0] retire_pc;
    logic [31:0]       cycle_cnt;
    logic [31:0]       inst_cnt;
    modport master (
        output inst_req, inst_addr, ir, pc, data_req, data_we, st_exec, rf_wen, exc, retire, retire_pc, cycle_cnt, inst_cnt,
        input  inst_ready, inst_rdata, dec_mem_rd, dec_mem_wr, dec_wb_en, dec_redirect, dec_target, data_ready
    );
    modport slave (
        input  inst_req, inst_addr, ir, pc, data_req, data_we, st_exec, rf_wen, exc, retire, retire_pc, cycle_cnt, inst_cnt,
        output inst_ready, inst_rdata, dec_mem_rd, dec_mem_wr, dec_wb_en, dec_redirect, dec_target, data_ready
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: 5-state multi-cycle sequencer/PC unit; ports clk, reset (sync, active-high), bus (mc_seq_ctrl_if.master); MC_SEQ_PERF_CNT_EN adds cycle/retire counters
module mc_seq_ctrl #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter logic [31:0] EXC_VEC  = 32'hbfc0_0380
) (
    input logic           clk,
    input logic           reset,
    mc_seq_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];
    typedef enum logic [4:0] {
        FETCH  = 5'b00001,
        DECODE = 5'b00010,
        EXEC   = 5'b00100,
        MEM    = 5'b01000,
        WB     = 5'b10000
    } state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0]       ir_q, ir_d;
    logic              misalign, mem_op;
    assign misalign = bus.dec_redirect && (bus.dec_target[1:0] != 2'b00);
    assign mem_op   = bus.dec_mem_rd || bus.dec_mem_wr;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RST_PC;
            npc_q   <= RST_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            ir_q    <= ir_d;
        end
    end
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = bus.inst_ready ? DECODE : FETCH;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = misalign ? FETCH : mem_op ? MEM : bus.dec_wb_en ? WB : FETCH;
            MEM:     state_d = !bus.data_ready ? MEM : bus.dec_mem_wr ? FETCH : WB;
            default: state_d = FETCH;
        endcase
    end
    // npc settles in EXEC; pc only moves on entry to FETCH, so it is frozen across both waits
    always_comb begin
        ir_d  = (state_q == FETCH && bus.inst_ready) ? bus.inst_rdata : ir_q;
        npc_d = state_q != EXEC ? npc_q : misalign ? EXC_PC : bus.dec_redirect ? bus.dec_target : pc_q + ADDR_W'(4);
        pc_d  = (state_q != FETCH && state_d == FETCH) ? npc_d : pc_q;
    end
    always_comb begin
        bus.inst_req  = !reset && state_q == FETCH;
        bus.inst_addr = pc_q;
        bus.ir        = ir_q;
        bus.pc        = pc_q;
        bus.data_req  = !reset && state_q == MEM;
        bus.data_we   = !reset && state_q == MEM && bus.dec_mem_wr;
        bus.st_exec   = !reset && state_q == EXEC;
        bus.rf_wen    = !reset && state_q == WB;
        bus.exc       = !reset && state_q == EXEC && misalign;
        bus.retire    = !reset && (state_q == EXEC ? (misalign || (!mem_op && !bus.dec_wb_en)) :
                                   state_q == MEM  ? (bus.data_ready && bus.dec_mem_wr) :
                                   state_q == WB);
        bus.retire_pc = pc_q;
    end
`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, inst_cnt_q, inst_cnt_d;
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + {31'd0, bus.retire};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.inst_cnt  = inst_cnt_q;
`else
    assign bus.cycle_cnt = '0;
    assign bus.inst_cnt  = '0;
`endif
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl: randomized per-instruction timeline model checked cycle by cycle against mc_seq_ctrl
module tb_mc_seq_ctrl;
    localparam logic [31:0] RST  = 32'hbfc0_0000;
    localparam logic [31:0] EXCV = 32'hbfc0_0380;
    typedef logic [70:0] tr_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    mc_seq_ctrl_if #(.ADDR_W(32)) bus ();
    mc_seq_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
    int n_cmp = 0;
    int n_bad = 0;
    int cyc_done = 0;
    int ret_done = 0;
    logic [31:0] pc_m = RST;
    logic [31:0] ir_exp = '0, ir_prev = '0, ir_pre = '0, ir_post = '0;
    tr_t exp_q[$], obs_q[$];
    logic [1:0] stim_q[$];

    function automatic tr_t ent(input logic [6:0] s, input logic [31:0] a);
        return {s, s[6] ? a : 32'h0, s[0] ? a : 32'h0};
    endfunction

    function automatic logic rnd(input bit en);
        return en ? 1'($urandom_range(1)) : 1'b0;
    endfunction

    // strobe order {inst_req, data_req, data_we, st_exec, rf_wen, exc, retire}; stim {inst_ready, data_ready}
    task automatic model(input int fw, input bit rd, input bit wr, input bit wb, input bit redir,
                         input logic [31:0] tgt, input int mw, input bit stray);
        bit mis, mem, wbp, rex;
        mis = redir && tgt[1:0] != 2'b00;
        mem = (rd || wr) && !mis;
        wbp = !mis && (mem ? !wr : wb);
        rex = mis || (!mem && !wbp);
        exp_q = {};
        stim_q = {};
        for (int i = 0; i <= fw; i++) begin
            exp_q.push_back(ent(7'b1000000, pc_m));
            stim_q.push_back({i == fw, rnd(stray)});
        end
        exp_q.push_back(ent(7'b0, pc_m));
        stim_q.push_back({rnd(stray), rnd(stray)});
        exp_q.push_back(ent({4'b0001, 1'b0, mis, rex}, pc_m));
        stim_q.push_back({rnd(stray), rnd(stray)});
        if (mem)
            for (int j = 0; j <= mw; j++) begin
                exp_q.push_back(ent({2'b01, wr, 3'b000, j == mw && wr}, pc_m));
                stim_q.push_back({rnd(stray), j == mw});
            end
        if (wbp) begin
            exp_q.push_back(ent(7'b0000101, pc_m));
            stim_q.push_back({rnd(stray), rnd(stray)});
        end
        pc_m = mis ? EXCV : redir ? tgt : pc_m + 32'd4;
    endtask

    task automatic run(input int fw, input bit rd, input bit wr, input bit wb, input bit redir,
                       input logic [31:0] tgt, input int mw, input bit stray, input int cut);
        logic [31:0] rdata;
        model(fw, rd, wr, wb, redir, tgt, mw, stray);
        obs_q = {};
        ir_prev = ir_exp;
        for (int i = 0; i < stim_q.size() && i < cut; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.dec_mem_rd = rd;
                bus.dec_mem_wr = wr;
                bus.dec_wb_en = wb;
                bus.dec_redirect = redir;
                bus.dec_target = tgt;
            end
            rdata = $urandom;
            bus.inst_rdata = rdata;
            bus.inst_ready = stim_q[i][1];
            bus.data_ready = stim_q[i][0];
            #1;
            obs_q.push_back({bus.inst_req, bus.data_req, bus.data_we, bus.st_exec, bus.rf_wen, bus.exc, bus.retire,
                             bus.inst_req ? bus.inst_addr : 32'h0, bus.retire ? bus.retire_pc : 32'h0});
            if (exp_q[i][70] && stim_q[i][1]) begin
                ir_pre = bus.ir;
                ir_exp = rdata;
            end
            if (i > 0 && exp_q[i-1][70] && !exp_q[i][70]) ir_post = bus.ir;
            cyc_done++;
            ret_done += int'(exp_q[i][64]);
        end
    endtask

    task automatic test_reset;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset = 1'b1;
            bus.inst_ready = 1'b0; bus.data_ready = 1'b0; bus.inst_rdata = '0;
            bus.dec_mem_rd = 1'b0; bus.dec_mem_wr = 1'b0; bus.dec_wb_en = 1'b0;
            bus.dec_redirect = 1'b0; bus.dec_target = '0;
            #1;
            n_cmp++;
            if ({bus.inst_req, bus.data_req, bus.st_exec, bus.rf_wen, bus.exc, bus.retire} !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_strobes c%0d got %b want 000000", c,
                         {bus.inst_req, bus.data_req, bus.st_exec, bus.rf_wen, bus.exc, bus.retire});
            end
        end
        n_cmp++;
        if (bus.pc !== RST || bus.ir !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state got pc=%h ir=%h want pc=%h ir=0", bus.pc, bus.ir, RST);
        end
        n_cmp++;
        if (bus.cycle_cnt !== 32'h0 || bus.inst_cnt !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.cycle_cnt, bus.inst_cnt);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        pc_m = RST; ir_exp = '0; cyc_done = 0; ret_done = 0;
    endtask

    task automatic test_alu;
        run(0, 0, 0, 1, 0, 32'h0, 0, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL alu c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (ir_post !== ir_exp) begin n_bad++; $display("FAIL alu_ir got %h want %h", ir_post, ir_exp); end
    endtask

    task automatic test_fetch_wait;
        run(3, 0, 0, 1, 0, 32'h0, 0, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fetch_wait c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (ir_pre !== ir_prev) begin n_bad++; $display("FAIL fetch_wait_ir_hold got %h want %h", ir_pre, ir_prev); end
        n_cmp++;
        if (ir_post !== ir_exp) begin n_bad++; $display("FAIL fetch_wait_ir got %h want %h", ir_post, ir_exp); end
    endtask

    task automatic test_load_store;
        run(1, 1, 0, 0, 0, 32'h0, 2, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL load c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        run(0, 0, 1, 0, 0, 32'h0, 1, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL store c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        run(0, 1, 1, 1, 0, 32'h0, 0, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rdwr_store c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_redirect;
        run(0, 0, 0, 0, 1, 32'hbfc0_0100, 0, 0, 1000);
        run(0, 0, 0, 0, 1, 32'hbfc0_0102, 0, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL jump_misaligned c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        run(0, 1, 0, 1, 1, 32'hffff_fffc, 0, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL branch c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        run(0, 0, 0, 0, 0, 32'h0, 0, 0, 1000);
        run(0, 0, 0, 0, 0, 32'h0, 0, 0, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL pc_wrap c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] tgt;
        for (int k = 0; k < 60; k++) begin
            tgt = $urandom;
            if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
            run($urandom_range(3), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                1'($urandom_range(1)), tgt, $urandom_range(3), 1, 1000);
            foreach (exp_q[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random k%0d c%0d got %h want %h", k, i, obs_q[i], exp_q[i]); end
            end
            n_cmp++;
            if (ir_post !== ir_exp) begin n_bad++; $display("FAIL random_ir k%0d got %h want %h", k, ir_post, ir_exp); end
        end
    endtask

    task automatic test_counters;
        logic [31:0] ec, ei;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.data_ready = 1'b0;
        #1;
`ifdef MC_SEQ_PERF_CNT_EN
        ec = cyc_done; ei = ret_done;
`else
        ec = 0; ei = 0;
`endif
        n_cmp++;
        if (bus.cycle_cnt !== ec || bus.inst_cnt !== ei) begin
            n_bad++;
            $display("FAIL counters got %0d/%0d want %0d/%0d", bus.cycle_cnt, bus.inst_cnt, ec, ei);
        end
        cyc_done++;
    endtask

    task automatic test_reset_mid;
        run(0, 1, 0, 0, 0, 32'h0, 5, 0, 5);
        foreach (obs_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_pre c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        @(negedge clk);
        reset = 1'b1;
        bus.data_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.inst_req, bus.data_req, bus.retire} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_reset got %b want 000", {bus.inst_req, bus.data_req, bus.retire});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        pc_m = RST; ir_exp = '0; cyc_done = 0; ret_done = 0;
        @(negedge clk);
        bus.data_ready = 1'b1;
        bus.inst_ready = 1'b0;
        #1;
        n_cmp++;
        if ({bus.inst_req, bus.data_req, bus.retire} !== 3'b100 || bus.inst_addr !== RST) begin
            n_bad++;
            $display("FAIL mid_after got %b addr %h want 100 addr %h", {bus.inst_req, bus.data_req, bus.retire}, bus.inst_addr, RST);
        end
        n_cmp++;
        if (bus.cycle_cnt !== 32'h0 || bus.inst_cnt !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_cnt got %0d/%0d want 0/0", bus.cycle_cnt, bus.inst_cnt);
        end
        cyc_done++;
        run(0, 0, 0, 1, 0, 32'h0, 0, 1, 1000);
        foreach (exp_q[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL mid_resume c%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_fetch_wait;
        test_load_store;
        test_redirect;
        test_counters;
        test_random;
        test_counters;
        test_reset_mid;
        test_counters;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
